alu_ctrl_seq: RTL and testbench

//  Registered, handshaked ALU control decoder. Replaces the combinational ALUOp/func7 decoder

---
 rtl/alu_ctrl_seq.sv | 186 ++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control decoder with RV32M support.
// It stalls new requests while a multi-cycle MUL/DIV is in flight.
module alu_ctrl_seq #(
  parameter int M_EXT   = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_ctrl,
  output logic [2:0] alu_f3,
  output logic       illegal,
  output logic       busy,
  output logic       mc_done
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;
  localparam logic [3:0] OP_BR    = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [2:0]       f3_q, f3_d;
  logic             ill_q, ill_d;
  logic [3:0]       decCtrl;
  logic             decIll;
  logic             accept;

  function automatic logic [3:0] baseOp(input logic [2:0] f3);
    case (f3)
      3'b000:  baseOp = OP_ADD;
      3'b001:  baseOp = OP_SLL;
      3'b010:  baseOp = OP_SLT;
      3'b011:  baseOp = OP_SLTU;
      3'b100:  baseOp = OP_XOR;
      3'b101:  baseOp = OP_SRL;
      3'b110:  baseOp = OP_OR;
      default: baseOp = OP_AND;
    endcase
  endfunction

  always_comb begin
    decCtrl = OP_ADD;
    decIll  = 1'b0;
    case (ALUOp)
      3'b000: begin
        if (funct7 == F7_ZERO) begin
          decCtrl = baseOp(funct3);
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      decCtrl = OP_SUB;
          else if (funct3 == 3'b101) decCtrl = OP_SRA;
          else                       decIll  = 1'b1;
        end else if (funct7 == F7_MEXT && M_EXT != 0) begin
          decCtrl = funct3[2] ? OP_DIV : OP_MUL;
        end else begin
          decIll = 1'b1;
        end
      end
      3'b001: begin
        // I-type funct7 is immediate data except for the shift encodings.
        if (funct3 == 3'b001) begin
          if (funct7 == F7_ZERO) decCtrl = OP_SLL;
          else                   decIll  = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ZERO)     decCtrl = OP_SRL;
          else if (funct7 == F7_ALT) decCtrl = OP_SRA;
          else                       decIll  = 1'b1;
        end else begin
          decCtrl = baseOp(funct3);
        end
      end
      3'b011:         decCtrl = OP_BR;
      3'b100, 3'b101: decCtrl = OP_PASSB;
      default:        decCtrl = OP_ADD;
    endcase
    if (decIll) decCtrl = OP_ADD;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    f3_d      = f3_q;
    ill_d     = ill_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    mc_done   = 1'b0;
    case (state_q)
      IDLE:    in_ready = !flush;
      ISSUE: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !flush && (ctrl_q < OP_MUL);
      end
      WAIT: begin
        busy    = 1'b1;
        mc_done = (cnt_q == '0) && !flush;
      end
      default: ;
    endcase
    accept = in_valid && in_ready;

    case (state_q)
      IDLE: if (accept) state_d = ISSUE;
      ISSUE: begin
        if (out_ready) begin
          if (ctrl_q >= OP_MUL && !ill_q) begin
            state_d = WAIT;
            cnt_d   = (ctrl_q == OP_MUL) ? MUL_CNT : DIV_CNT;
          end else if (accept) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      ctrl_d = decCtrl;
      f3_d   = funct3;
      ill_d  = decIll;
    end
    // Flush beats everything, including a completing MUL/DIV.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= OP_ADD;
      f3_q    <= 3'b000;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      f3_q    <= f3_d;
      ill_q   <= ill_d;
    end
  end

  assign alu_ctrl = ctrl_q;
  assign alu_f3   = f3_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: directed literal checks plus randomized traffic
// compared every cycle against a cycle-level behavioural model.
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, inValid, outReady;
  logic [2:0] aluOp, funct3;
  logic [6:0] funct7;
  logic       inReady, outValid, illegal, busy, mcDone;
  logic [3:0] aluCtrl;
  logic [2:0] aluF3;

  logic       zValid, zOutReady;
  logic       zInReady, zOutValid, zIllegal, zBusy, zMcDone;
  logic [3:0] zAluCtrl;
  logic [2:0] zAluF3;

  int nPass  = 0;
  int nTotal = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.M_EXT(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(inReady),
    .ALUOp(aluOp), .funct3(funct3), .funct7(funct7),
    .out_valid(outValid), .out_ready(outReady),
    .alu_ctrl(aluCtrl), .alu_f3(aluF3), .illegal(illegal),
    .busy(busy), .mc_done(mcDone)
  );

  // Second instance without the M extension, driven only by the directed test.
  alu_ctrl_seq #(.M_EXT(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dutNoM (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(zValid), .in_ready(zInReady),
    .ALUOp(3'b000), .funct3(3'b000), .funct7(7'b0000001),
    .out_valid(zOutValid), .out_ready(zOutReady),
    .alu_ctrl(zAluCtrl), .alu_f3(zAluF3), .illegal(zIllegal),
    .busy(zBusy), .mc_done(zMcDone)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTotal++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drives one cycle of inputs at the falling edge, then settles for checking.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic ordy, input logic fl);
    @(negedge clk);
    inValid = v; aluOp = op; funct3 = f3; funct7 = f7; outReady = ordy; flush = fl;
    #3;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 3'b000, 3'b000, 7'h00, 1'b1, 1'b0);
  endtask

  // Reference decoder written from the encoding table.
  function automatic void refDecode(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                    output int ctrl, output bit ill);
    int plain [8];
    plain = '{0, 2, 3, 4, 5, 6, 8, 9};
    ctrl = 0;
    ill  = 1'b0;
    case (op)
      3'd0: begin
        if (f7 == 7'h00)                   ctrl = plain[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) ctrl = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) ctrl = 7;
        else if (f7 == 7'h01)              ctrl = (f3 >= 3'd4) ? 13 : 12;
        else                               ill  = 1'b1;
      end
      3'd1: begin
        if (f3 == 3'd1 && f7 != 7'h00)      ill  = 1'b1;
        else if (f3 == 3'd5 && f7 == 7'h20) ctrl = 7;
        else if (f3 == 3'd5 && f7 != 7'h00) ill  = 1'b1;
        else                               ctrl = plain[f3];
      end
      3'd3:       ctrl = 11;
      3'd4, 3'd5: ctrl = 10;
      default:    ctrl = 0;
    endcase
    if (ill) ctrl = 0;
  endfunction

  // Model: a pending output slot plus a count of remaining busy cycles.
  bit mHold;
  int mCtrl;
  int mF3;
  bit mIll;
  int mWaitLeft;

  function automatic bit mIsMulDiv();
    return (mCtrl == 12 || mCtrl == 13) && !mIll;
  endfunction

  function automatic bit mInReady();
    if (flush)          return 1'b0;
    if (mWaitLeft > 0)  return 1'b0;
    if (mHold)          return outReady && !mIsMulDiv();
    return 1'b1;
  endfunction

  task automatic modelReset();
    mHold = 1'b0; mCtrl = 0; mF3 = 0; mIll = 1'b0; mWaitLeft = 0;
  endtask

  task automatic modelStep();
    bit acc;
    int c;
    bit il;
    acc = inValid && mInReady();
    if (flush) begin
      mHold = 1'b0;
      mWaitLeft = 0;
    end else if (mWaitLeft > 0) begin
      mWaitLeft--;
    end else if (mHold && outReady && mIsMulDiv()) begin
      mHold = 1'b0;
      mWaitLeft = (mCtrl == 12) ? MUL_LAT : DIV_LAT;
    end else if (mHold && !outReady) begin
      mHold = 1'b1;
    end else if (acc) begin
      refDecode(aluOp, funct3, funct7, c, il);
      mHold = 1'b1; mCtrl = c; mIll = il; mF3 = int'(funct3);
    end else begin
      mHold = 1'b0;
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) modelReset();
      checkOutput("m_in_ready",  inReady,  mInReady());
      checkOutput("m_out_valid", outValid, mHold);
      checkOutput("m_busy",      busy,     mWaitLeft > 0);
      checkOutput("m_mc_done",   mcDone,   (mWaitLeft == 1) && !flush);
      if (mHold) begin
        checkOutput("m_alu_ctrl", aluCtrl, mCtrl);
        checkOutput("m_alu_f3",   aluF3,   mF3);
        checkOutput("m_illegal",  illegal, mIll);
      end
      @(posedge clk);
      if (rst_n) modelStep();
    end
  end

  initial begin
    int pulses;
    rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    aluOp = 3'd0; funct3 = 3'd0; funct7 = 7'd0;
    zValid = 1'b0; zOutReady = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_alu_ctrl",  aluCtrl,  0);
    checkOutput("rst_alu_f3",    aluF3,    0);
    checkOutput("rst_illegal",   illegal,  0);
    checkOutput("rst_busy",      busy,     0);
    checkOutput("rst_mc_done",   mcDone,   0);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    checkOutput("idle_in_ready", inReady, 1);

    applyStimulus(1'b1, 3'd0, 3'd0, 7'h20, 1'b1, 1'b0);
    idleCycle();
    checkOutput("sub_valid", outValid, 1);
    checkOutput("sub_ctrl",  aluCtrl,  1);
    checkOutput("sub_ill",   illegal,  0);

    applyStimulus(1'b1, 3'd1, 3'd0, 7'h20, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd1, 3'd5, 7'h20, 1'b1, 1'b0);
    checkOutput("addi_neg_ctrl", aluCtrl, 0);
    idleCycle();
    checkOutput("srai_ctrl", aluCtrl, 7);

    applyStimulus(1'b1, 3'd3, 3'd2, 7'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd4, 3'd0, 7'h00, 1'b1, 1'b0);
    checkOutput("b2b_br", aluCtrl, 11);
    applyStimulus(1'b1, 3'd2, 3'd2, 7'h00, 1'b1, 1'b0);
    checkOutput("b2b_passb", aluCtrl, 10);
    applyStimulus(1'b1, 3'd7, 3'd0, 7'h00, 1'b1, 1'b0);
    checkOutput("b2b_store", aluCtrl, 0);
    idleCycle();
    checkOutput("b2b_jalr",  aluCtrl, 0);
    checkOutput("b2b_valid", outValid, 1);

    applyStimulus(1'b1, 3'd0, 3'd7, 7'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd2, 3'd0, 7'h00, 1'b0, 1'b0);
      checkOutput("hold_valid", outValid, 1);
      checkOutput("hold_ctrl",  aluCtrl,  9);
      checkOutput("hold_f3",    aluF3,    7);
      checkOutput("hold_ready", inReady,  0);
    end
    idleCycle();
    checkOutput("hold_release", aluCtrl, 9);

    applyStimulus(1'b1, 3'd0, 3'd0, 7'h02, 1'b1, 1'b0);
    idleCycle();
    checkOutput("bad_f7_ill",  illegal, 1);
    checkOutput("bad_f7_ctrl", aluCtrl, 0);

    applyStimulus(1'b1, 3'd0, 3'd4, 7'h01, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd4, 3'd0, 7'h00, 1'b1, 1'b0);
    checkOutput("div_ctrl",  aluCtrl, 13);
    checkOutput("div_f3",    aluF3,   4);
    checkOutput("div_ready", inReady, 0);
    pulses = 0;
    for (int i = 0; i < DIV_LAT; i++) begin
      applyStimulus(1'b1, 3'd4, 3'd0, 7'h00, 1'b1, 1'b0);
      checkOutput("div_busy",     busy,    1);
      checkOutput("div_in_ready", inReady, 0);
      if (mcDone) pulses++;
      if (i == DIV_LAT - 1) checkOutput("div_done_last", mcDone, 1);
    end
    checkOutput("div_pulses", pulses, 1);
    idleCycle();
    checkOutput("div_after_busy",  busy,    0);
    checkOutput("div_after_ready", inReady, 1);

    applyStimulus(1'b1, 3'd0, 3'd0, 7'h01, 1'b1, 1'b0);
    idleCycle();
    checkOutput("mul_ctrl", aluCtrl, 12);
    applyStimulus(1'b0, 3'd0, 3'd0, 7'h00, 1'b1, 1'b1);
    checkOutput("flush_busy_now", busy, 1);
    idleCycle();
    checkOutput("flush_busy",  busy,     0);
    checkOutput("flush_done",  mcDone,   0);
    checkOutput("flush_valid", outValid, 0);
    idleCycle();
    checkOutput("flush_done2", mcDone, 0);

    applyStimulus(1'b1, 3'd0, 3'd0, 7'h00, 1'b1, 1'b1);
    checkOutput("flush_in_ready", inReady, 0);
    idleCycle();
    checkOutput("flush_no_accept", outValid, 0);

    applyStimulus(1'b1, 3'd0, 3'd1, 7'h01, 1'b1, 1'b0);
    idleCycle();
    checkOutput("mul2_ctrl", aluCtrl, 12);
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    checkOutput("rst_wait_busy", busy,   0);
    checkOutput("rst_wait_done", mcDone, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    checkOutput("rst_wait_busy2",  busy,     0);
    checkOutput("rst_wait_done2",  mcDone,   0);
    checkOutput("rst_wait_valid",  outValid, 0);
    idleCycle();
    checkOutput("rst_wait_done3", mcDone, 0);

    @(negedge clk);
    zValid = 1'b1;
    #3;
    checkOutput("nom_in_ready", zInReady, 1);
    @(negedge clk);
    zValid = 1'b0;
    #3;
    checkOutput("nom_valid",   zOutValid, 1);
    checkOutput("nom_illegal", zIllegal,  1);
    checkOutput("nom_ctrl",    zAluCtrl,  0);
    @(negedge clk);
    #3;
    checkOutput("nom_busy",  zBusy,     0);
    checkOutput("nom_idle",  zOutValid, 0);

    for (int cyc = 0; cyc < 2500; cyc++) begin
      int r;
      logic [6:0] f7;
      r = $urandom_range(0, 9);
      if (r < 4)      f7 = 7'h00;
      else if (r < 6) f7 = 7'h20;
      else if (r < 8) f7 = 7'h01;
      else            f7 = 7'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      applyStimulus($urandom_range(0, 9) < 7, 3'($urandom), 3'($urandom), f7,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end

    idleCycle();
    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
